// File: rtl/miner_host_regs.sv
// Register front end for the multi-miner supervisor: header/target config, start/abort sequencing and result capture.
// Optional run timeout (TIMEOUT register, STATUS bit3) is built in when MINER_HOST_TIMEOUT_EN is defined.
module miner_host_regs #(
   parameter int ADDR_W  = 6,
   parameter int CYCLE_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reg_wr_en,
   input  logic              reg_rd_en,
   input  logic [ADDR_W-1:0] reg_addr,
   input  logic [31:0]       reg_wdata,
   output logic [31:0]       reg_rdata,
   output logic              reg_rd_valid,
   output logic              irq,
   output logic              sup_reset,
   output logic              sup_start,
   output logic [31:0]       version,
   output logic [31:0]       timestamp,
   output logic [31:0]       bits,
   output logic [31:0]       target_bits,
   output logic [255:0]      hashPrevBlock,
   output logic [255:0]      hashMerkleRoot,
   input  logic              process_complete,
   input  logic              success,
   input  logic [255:0]      hash_out,
   input  logic [31:0]       nonce_out
);

   typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

   state_t             state, state_nxt;
   logic [31:0]        word;
   logic [31:0]        hash_prev [8];
   logic [31:0]        hash_merkle [8];
   logic [31:0]        cap_hash [8];
   logic [31:0]        cap_nonce;
   logic [CYCLE_W-1:0] cycle_cnt, cnt_inc;
   logic               irq_en, done, found, timed_out;
   logic               busy, ctrl_wr, start_req, abort_req, cfg_wr, launch, capture, tmo_hit;
   logic [31:0]        rd_mux;
`ifdef MINER_HOST_TIMEOUT_EN
   logic [31:0]        timeout_lim;
`endif

   assign word      = 32'(reg_addr);
   assign busy      = (state == LAUNCH) || (state == RUN);
   assign ctrl_wr   = reg_wr_en && (word == 0);
   assign abort_req = ctrl_wr && reg_wdata[1];
   assign start_req = ctrl_wr && reg_wdata[0] && !reg_wdata[1];
   // Header and target are frozen while the supervisor is running.
   assign cfg_wr    = reg_wr_en && !busy;
   assign launch    = (state == IDLE) && start_req;
   assign cnt_inc   = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CYCLE_W'(1);
   assign capture   = (state == RUN) && process_complete && !abort_req;

`ifdef MINER_HOST_TIMEOUT_EN
   assign tmo_hit = (state == RUN) && !process_complete && !abort_req &&
                    (timeout_lim != 0) && (32'(cnt_inc) == timeout_lim);
`else
   assign tmo_hit = 1'b0;
`endif

   assign sup_reset = !busy;
   assign sup_start = busy;
   assign irq       = done & irq_en;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start_req) state_nxt = LAUNCH;
         LAUNCH:  state_nxt = abort_req ? IDLE : RUN;
         RUN:     if (abort_req)               state_nxt = IDLE;
                  else if (capture || tmo_hit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         hashPrevBlock[i*32 +: 32]  = hash_prev[i];
         hashMerkleRoot[i*32 +: 32] = hash_merkle[i];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         version     <= '0;
         timestamp   <= '0;
         bits        <= '0;
         target_bits <= '0;
`ifdef MINER_HOST_TIMEOUT_EN
         timeout_lim <= '0;
`endif
         // NOTE: these small arrays are flops, not RAM, so they can and must be cleared by reset.
         for (int i = 0; i < 8; i++) begin
            hash_prev[i]   <= '0;
            hash_merkle[i] <= '0;
            cap_hash[i]    <= '0;
         end
         cap_nonce    <= '0;
         cycle_cnt    <= '0;
         irq_en       <= 1'b0;
         done         <= 1'b0;
         found        <= 1'b0;
         timed_out    <= 1'b0;
         reg_rdata    <= '0;
         reg_rd_valid <= 1'b0;
      end else begin
         if (cfg_wr) begin
            case (word) inside
               4:        target_bits <= reg_wdata;
`ifdef MINER_HOST_TIMEOUT_EN
               5:        timeout_lim <= reg_wdata;
`endif
               7:        version <= reg_wdata;
               [8:15]:   hash_prev[word[2:0]] <= reg_wdata;
               [16:23]:  hash_merkle[word[2:0]] <= reg_wdata;
               24:       timestamp <= reg_wdata;
               25:       bits <= reg_wdata;
               default:  ;
            endcase
         end
         if (ctrl_wr) irq_en <= reg_wdata[2];
         if ((reg_wr_en && (word == 1) && reg_wdata[1]) || launch) begin
            done      <= 1'b0;
            found     <= 1'b0;
            timed_out <= 1'b0;
         end
         if (launch)             cycle_cnt <= '0;
         else if (state == RUN)  cycle_cnt <= cnt_inc;
         if (capture) begin
            for (int i = 0; i < 8; i++) cap_hash[i] <= hash_out[i*32 +: 32];
            cap_nonce <= nonce_out;
            found     <= success;
            done      <= 1'b1;
         end
         if (tmo_hit) begin
            done      <= 1'b1;
            timed_out <= 1'b1;
            found     <= 1'b0;
         end
         reg_rd_valid <= reg_rd_en;
         if (reg_rd_en) reg_rdata <= rd_mux;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (word) inside
         0:        rd_mux = {29'd0, irq_en, 2'b00};
         1:        rd_mux = {28'd0, timed_out, found, done, busy};
         4:        rd_mux = target_bits;
`ifdef MINER_HOST_TIMEOUT_EN
         5:        rd_mux = timeout_lim;
`endif
         7:        rd_mux = version;
         [8:15]:   rd_mux = hash_prev[word[2:0]];
         [16:23]:  rd_mux = hash_merkle[word[2:0]];
         24:       rd_mux = timestamp;
         25:       rd_mux = bits;
         [32:39]:  rd_mux = cap_hash[word[2:0]];
         40:       rd_mux = cap_nonce;
         41:       rd_mux = 32'(cycle_cnt);
         default:  rd_mux = '0;
      endcase
   end

endmodule

// File: tb/tb_miner_host_regs.sv
// Self-checking bench for miner_host_regs: randomized register traffic and a stub supervisor against a register-map model.
// Define MINER_HOST_TIMEOUT_EN for both bench and RTL to exercise the timeout path.
module tb_miner_host_regs;

   logic         clk = 1'b0;
   logic         reset, reg_wr_en, reg_rd_en;
   logic [5:0]   reg_addr;
   logic [31:0]  reg_wdata, reg_rdata;
   logic         reg_rd_valid, irq, sup_reset, sup_start;
   logic [31:0]  version, timestamp, bits, target_bits;
   logic [255:0] hashPrevBlock, hashMerkleRoot;
   logic         process_complete, success;
   logic [255:0] hash_out;
   logic [31:0]  nonce_out;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef MINER_HOST_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif

   miner_host_regs #(.ADDR_W(6), .CYCLE_W(32)) dut (
      .clk(clk), .reset(reset), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
      .reg_rd_valid(reg_rd_valid), .irq(irq), .sup_reset(sup_reset), .sup_start(sup_start),
      .version(version), .timestamp(timestamp), .bits(bits), .target_bits(target_bits),
      .hashPrevBlock(hashPrevBlock), .hashMerkleRoot(hashMerkleRoot),
      .process_complete(process_complete), .success(success),
      .hash_out(hash_out), .nonce_out(nonce_out)
   );

   always #5 clk = ~clk;

   // Reference model: what each register address should read back.
   logic [31:0] m_cfg [64];
   logic [31:0] m_hash [8];
   logic [31:0] m_nonce, m_count;
   bit          m_irq_en, m_done, m_succ, m_tmo, m_busy;

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_cfg[i] = '0;
      for (int i = 0; i < 8; i++) m_hash[i] = '0;
      m_nonce = '0; m_count = '0;
      m_irq_en = 0; m_done = 0; m_succ = 0; m_tmo = 0; m_busy = 0;
   endtask

   function automatic bit is_cfg(int a);
      return (a == 4) || (a >= 7 && a <= 25) || (TMO && a == 5);
   endfunction

   task automatic model_write(int a, logic [31:0] d);
      if (a == 0) m_irq_en = d[2];
      if (a == 1 && d[1]) begin m_done = 0; m_succ = 0; m_tmo = 0; end
      if (is_cfg(a) && !m_busy) m_cfg[a] = d;
   endtask

   function automatic logic [31:0] exp_rd(int a);
      if (a == 0) return {29'd0, m_irq_en, 2'b00};
      if (a == 1) return {28'd0, m_tmo, m_succ, m_done, m_busy};
      if (a >= 32 && a <= 39) return m_hash[a-32];
      if (a == 40) return m_nonce;
      if (a == 41) return m_count;
      return m_cfg[a];
   endfunction

   function automatic logic [255:0] exp_hp(int base);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = m_cfg[base+i];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      model_write(a, d);
      reg_wr_en = 1'b1; reg_addr = 6'(a); reg_wdata = d;
      tick();
      reg_wr_en = 1'b0;
   endtask

   task automatic rd(input int a, output logic [31:0] d, output logic v);
      reg_rd_en = 1'b1; reg_addr = 6'(a);
      tick();
      d = reg_rdata; v = reg_rd_valid;
      reg_rd_en = 1'b0;
   endtask

   task automatic start_job();
      wr(0, {29'd0, m_irq_en, 2'b01});
      m_busy = 1; m_done = 0; m_succ = 0; m_tmo = 0; m_count = 0;
   endtask

   // Stub supervisor: completes k cycles after the start write; reports first cycle with a wrong handshake.
   task automatic run_job(input int k, input logic [31:0] nonce, input bit succ, output int bad_at);
      logic [31:0] hw [8];
      bad_at = -1;
      for (int i = 0; i < 8; i++) begin
         hw[i] = $urandom;
         hash_out[i*32 +: 32] = hw[i];
      end
      nonce_out = nonce; success = succ;
      if (sup_start !== 1'b1 || sup_reset !== 1'b0) bad_at = 0;
      for (int j = 1; j <= k; j++) begin
         process_complete = (j == k);
         tick();
         if (bad_at < 0 && j < k && (sup_start !== 1'b1 || sup_reset !== 1'b0)) bad_at = j;
         if (bad_at < 0 && j == k && (sup_start !== 1'b0 || sup_reset !== 1'b1)) bad_at = j;
      end
      process_complete = 1'b0; success = 1'b0;
      m_busy = 0; m_done = 1; m_succ = succ; m_nonce = nonce; m_count = k - 1;
      for (int i = 0; i < 8; i++) m_hash[i] = hw[i];
   endtask

   task automatic test_reset();
      logic [31:0] d; logic v;
      reset = 1'b1; tick(); tick(); reset = 1'b0;
      model_reset();
      n_cmp++;
      if ({sup_reset, sup_start, irq, reg_rd_valid} !== 4'b1000 || reg_rdata !== 32'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got rst/start/irq/rv=%b rdata=%h, expected 1000 rdata=0",
                  {sup_reset, sup_start, irq, reg_rd_valid}, reg_rdata);
      end
      for (int a = 0; a < 64; a++) begin
         rd(a, d, v);
         n_cmp++;
         if (v !== 1'b1 || d !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_read[%0d]: got %h valid %b, expected 0 valid 1", a, d, v);
         end
      end
   endtask

   task automatic test_header_start();
      logic [31:0] d; logic v; int bad;
      wr(7, 32'h1); wr(24, 32'd1305998791); wr(25, 32'd440711666); wr(4, 32'd16);
      for (int i = 0; i < 8; i++) wr(8 + i, $urandom);
      for (int i = 0; i < 8; i++) wr(16 + i, $urandom);
      start_job();
      run_job(22, 32'd2504433986, 1'b1, bad);
      n_cmp++;
      if (bad != -1) begin n_bad++; $display("FAIL hdr_handshake: wrong sup_start/sup_reset at cycle %0d, expected none", bad); end
      n_cmp++;
      if ({version, timestamp, bits, target_bits} !== {32'h1, 32'd1305998791, 32'd440711666, 32'd16}) begin
         n_bad++;
         $display("FAIL hdr_fields: got %h %h %h %h, expected 1 %h %h 10", version, timestamp, bits, target_bits,
                  32'd1305998791, 32'd440711666);
      end
      n_cmp++;
      if (hashPrevBlock !== exp_hp(8) || hashMerkleRoot !== exp_hp(16)) begin
         n_bad++;
         $display("FAIL hdr_hashes: got prev %h, expected %h", hashPrevBlock, exp_hp(8));
      end
      rd(1, d, v);
      n_cmp++;
      if (d !== 32'h6) begin n_bad++; $display("FAIL hdr_status: got %h, expected 6", d); end
      rd(40, d, v);
      n_cmp++;
      if (d !== 32'd2504433986) begin n_bad++; $display("FAIL hdr_nonce: got %0d, expected 2504433986", d); end
      rd(41, d, v);
      n_cmp++;
      if (d !== 32'd21) begin n_bad++; $display("FAIL hdr_cycles: got %0d, expected 21", d); end
      for (int a = 32; a < 40; a++) begin
         rd(a, d, v);
         n_cmp++;
         if (d !== exp_rd(a)) begin n_bad++; $display("FAIL hdr_hash_rd[%0d]: got %h, expected %h", a, d, exp_rd(a)); end
      end
   endtask

   task automatic test_irq();
      logic [31:0] d; logic v; int bad;
      wr(0, 32'h4);
      start_job();
      run_job(int'($urandom_range(2, 15)), $urandom, 1'($urandom), bad);
      n_cmp++;
      if (bad != -1) begin n_bad++; $display("FAIL irq_handshake: wrong at cycle %0d, expected none", bad); end
      n_cmp++;
      if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_set: got %b, expected 1", irq); end
      wr(1, 32'h2);
      n_cmp++;
      if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear: got %b, expected 0", irq); end
      rd(1, d, v);
      n_cmp++;
      if (d !== 32'd0) begin n_bad++; $display("FAIL irq_status: got %h, expected 0", d); end
   endtask

   task automatic test_rw_same();
      logic [31:0] d, old, nv; logic v;
      old = m_cfg[24]; nv = $urandom;
      reg_wr_en = 1'b1; reg_rd_en = 1'b1; reg_addr = 6'd24; reg_wdata = nv;
      tick();
      d = reg_rdata;
      reg_wr_en = 1'b0; reg_rd_en = 1'b0;
      model_write(24, nv);
      n_cmp++;
      if (d !== old) begin n_bad++; $display("FAIL rw_same_old: got %h, expected %h", d, old); end
      rd(24, d, v);
      n_cmp++;
      if (d !== nv) begin n_bad++; $display("FAIL rw_same_new: got %h, expected %h", d, nv); end
   endtask

   task automatic test_busy_writes();
      logic [31:0] d; logic v;
      start_job();
      tick(); tick(); tick();
      wr(7, 32'hDEAD);
      n_cmp++;
      if (version !== m_cfg[7]) begin n_bad++; $display("FAIL busy_version: got %h, expected %h", version, m_cfg[7]); end
      wr(0, {29'd0, m_irq_en, 2'b01});
      n_cmp++;
      if (sup_start !== 1'b1) begin n_bad++; $display("FAIL busy_start: sup_start %b, expected 1", sup_start); end
      wr(0, {29'd0, m_irq_en, 2'b10});
      m_busy = 0; m_count = 5;
      n_cmp++;
      if (sup_reset !== 1'b1 || sup_start !== 1'b0) begin
         n_bad++; $display("FAIL busy_abort: rst/start %b%b, expected 10", sup_reset, sup_start);
      end
      foreach (m_hash[i]) if (0) m_hash[i] = '0;
      for (int a = 40; a >= 0; a = a - 1) begin
         if (a != 1 && a != 40 && a != 41 && a != 7) continue;
         rd(a, d, v);
         n_cmp++;
         if (d !== exp_rd(a)) begin n_bad++; $display("FAIL busy_rd[%0d]: got %h, expected %h", a, d, exp_rd(a)); end
      end
      rd(41, d, v);
      n_cmp++;
      if (d !== 32'd5) begin n_bad++; $display("FAIL busy_cycles: got %0d, expected 5", d); end
   endtask

   task automatic test_abort_complete();
      logic [31:0] d; logic v;
      start_job();
      tick(); tick(); tick();
      nonce_out = $urandom; hash_out = {8{$urandom}}; success = 1'b1; process_complete = 1'b1;
      wr(0, {29'd0, m_irq_en, 2'b10});
      process_complete = 1'b0; success = 1'b0;
      m_busy = 0; m_count = 3;
      n_cmp++;
      if (sup_reset !== 1'b1 || sup_start !== 1'b0 || irq !== 1'b0) begin
         n_bad++; $display("FAIL abortpc_out: rst/start/irq %b%b%b, expected 100", sup_reset, sup_start, irq);
      end
      for (int a = 0; a < 42; a++) begin
         if (a != 1 && a != 32 && a != 39 && a != 40 && a != 41) continue;
         rd(a, d, v);
         n_cmp++;
         if (d !== exp_rd(a)) begin n_bad++; $display("FAIL abortpc_rd[%0d]: got %h, expected %h", a, d, exp_rd(a)); end
      end
   endtask

   task automatic test_random_runs();
      logic [31:0] d; logic v; int bad, a;
      for (int it = 0; it < 10; it++) begin
         for (int w = 0; w < int'($urandom_range(1, 6)); w++) begin
            a = int'($urandom_range(2, 63));
            if (a == 5) a = 6;
            wr(a, $urandom);
         end
         if ($urandom_range(0, 1) == 1) wr(1, 32'h2);
         start_job();
         run_job(int'($urandom_range(2, 40)), $urandom, 1'($urandom), bad);
         n_cmp++;
         if (bad != -1) begin n_bad++; $display("FAIL rnd%0d_handshake: wrong at cycle %0d, expected none", it, bad); end
         n_cmp++;
         if ({version, timestamp, bits, target_bits} !== {m_cfg[7], m_cfg[24], m_cfg[25], m_cfg[4]} ||
             hashPrevBlock !== exp_hp(8) || hashMerkleRoot !== exp_hp(16)) begin
            n_bad++; $display("FAIL rnd%0d_header: version %h timestamp %h, expected %h %h", it, version, timestamp,
                              m_cfg[7], m_cfg[24]);
         end
         n_cmp++;
         if (irq !== (m_done & m_irq_en)) begin n_bad++; $display("FAIL rnd%0d_irq: got %b, expected %b", it, irq, m_done & m_irq_en); end
         for (int r = 0; r < 5; r++) begin
            case (r)
               0: a = 1;
               1: a = 40;
               2: a = 41;
               3: a = int'($urandom_range(32, 39));
               default: a = int'($urandom_range(2, 31));
            endcase
            rd(a, d, v);
            n_cmp++;
            if (d !== exp_rd(a) || v !== 1'b1) begin
               n_bad++; $display("FAIL rnd%0d_rd[%0d]: got %h valid %b, expected %h", it, a, d, v, exp_rd(a));
            end
         end
      end
   endtask

   task automatic test_timeout();
      logic [31:0] d; logic v;
`ifdef MINER_HOST_TIMEOUT_EN
      int low_at;
      wr(5, 32'd10);
      start_job();
      low_at = -1;
      for (int j = 1; j <= 14; j++) begin
         tick();
         if (sup_start === 1'b0 && low_at < 0) low_at = j;
      end
      m_busy = 0; m_done = 1; m_tmo = 1; m_succ = 0; m_count = 10;
      n_cmp++;
      if (low_at != 11) begin n_bad++; $display("FAIL tmo_end_cycle: got %0d, expected 11", low_at); end
      rd(1, d, v);
      n_cmp++;
      if (d !== 32'hA) begin n_bad++; $display("FAIL tmo_status: got %h, expected a", d); end
      rd(41, d, v);
      n_cmp++;
      if (d !== 32'd10) begin n_bad++; $display("FAIL tmo_cycles: got %0d, expected 10", d); end
      rd(40, d, v);
      n_cmp++;
      if (d !== m_nonce) begin n_bad++; $display("FAIL tmo_nonce: got %h, expected %h", d, m_nonce); end
      wr(5, 32'd0);
`else
      wr(5, 32'd10);
      rd(5, d, v);
      n_cmp++;
      if (d !== 32'd0) begin n_bad++; $display("FAIL notmo_addr5: got %h, expected 0", d); end
      rd(1, d, v);
      n_cmp++;
      if (d !== exp_rd(1)) begin n_bad++; $display("FAIL notmo_status: got %h, expected %h", d, exp_rd(1)); end
`endif
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] d; logic v;
      start_job();
      tick(); tick(); tick(); tick();
      reset = 1'b1; tick(); reset = 1'b0;
      model_reset();
      n_cmp++;
      if ({sup_reset, sup_start, irq, reg_rd_valid} !== 4'b1000 ||
          {version, timestamp, bits, target_bits} !== 128'd0 || hashPrevBlock !== 256'd0) begin
         n_bad++; $display("FAIL midrst_outputs: rst/start/irq/rv=%b version %h, expected 1000 and 0",
                           {sup_reset, sup_start, irq, reg_rd_valid}, version);
      end
      for (int a = 0; a < 64; a++) begin
         rd(a, d, v);
         n_cmp++;
         if (d !== exp_rd(a)) begin n_bad++; $display("FAIL midrst_rd[%0d]: got %h, expected %h", a, d, exp_rd(a)); end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; reg_wr_en = 1'b0; reg_rd_en = 1'b0; reg_addr = '0; reg_wdata = '0;
      process_complete = 1'b0; success = 1'b0; hash_out = '0; nonce_out = '0;
      test_reset();
      test_header_start();
      test_irq();
      test_rw_same();
      test_busy_writes();
      test_abort_complete();
      test_random_runs();
      test_timeout();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
